regfile_sb: RTL and testbench

//  Parametrised successor of the 8x16 MIPS register file. Width, depth and number of

---
 rtl/regfile_sb.sv | 97 +++++++++
 tb/tb_regfile_sb.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Parametrised register file with a pending-write scoreboard, per-port stall detection and
// registered ALU compare flags. Optional write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned NUM_RD   = 3,
    parameter int unsigned ZERO_R0  = 0
) (
    input  logic                             clk_i,
    input  logic                             rst,
    input  logic [NUM_RD-1:0]                rd_ena_i,
    input  logic [NUM_RD*$clog2(NUM_REGS)-1:0] rd_adr_i,
    output logic [NUM_RD*DATA_W-1:0]         rd_data_o,
    output logic [NUM_RD-1:0]                rd_busy_o,
    output logic                             stall_o,
    input  logic                             iss_ena_i,
    input  logic [$clog2(NUM_REGS)-1:0]      iss_adr_i,
    input  logic                             wr_ena_i,
    input  logic [$clog2(NUM_REGS)-1:0]      wr_adr_i,
    input  logic [DATA_W-1:0]                wr_data_i,
    input  logic                             flag_wr_i,
    input  logic [2:0]                       flag_cmp_i,
    input  logic                             flag_ra_wr_i,
    input  logic                             flag_ra_i,
    input  logic [3:0]                       flag_ena_i,
    output logic [3:0]                       flag_o
);

    localparam int unsigned AW = $clog2(NUM_REGS);
    localparam bit          Z0 = (ZERO_R0 != 0);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [2:0]          r_cmp;
    logic                r_rav;

    logic [NUM_REGS-1:0] w_wr_hit;
    logic [NUM_REGS-1:0] w_iss_hit;

    // Decoded write/issue targets; a hardwired r0 never accepts either.
    always_comb begin
        w_wr_hit  = '0;
        w_iss_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_hit[i]  = wr_ena_i  && (wr_adr_i  == AW'(i)) && !(Z0 && (i == 0));
            w_iss_hit[i] = iss_ena_i && (iss_adr_i == AW'(i)) && !(Z0 && (i == 0));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
            r_cmp  <= '0;
            r_rav  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_hit[i]) begin
                    r_regs[i] <= wr_data_i;
                end
            end
            // A same-cycle issue wins over the clear: the new producer is still pending.
            r_busy <= (r_busy & ~w_wr_hit) | w_iss_hit;
            if (flag_wr_i) begin
                r_cmp <= flag_cmp_i;
            end
            if (flag_ra_wr_i) begin
                r_rav <= flag_ra_i;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] w_adr;
        logic          w_zero;
        logic          w_byp;

        assign w_adr  = rd_adr_i[k*AW +: AW];
        assign w_zero = Z0 && (w_adr == '0);
`ifdef REGFILE_BYPASS_EN
        assign w_byp  = wr_ena_i && (wr_adr_i == w_adr) && !w_zero;
`else
        assign w_byp  = 1'b0;
`endif
        assign rd_data_o[k*DATA_W +: DATA_W] = (!rd_ena_i[k] || w_zero) ? '0 :
                                               w_byp ? wr_data_i : r_regs[w_adr];
        // Bypassed reads see the retiring write, so only a same-cycle reissue keeps them busy.
        assign rd_busy_o[k] = rd_ena_i[k] && !w_zero &&
                              (w_byp ? (iss_ena_i && (iss_adr_i == w_adr)) : r_busy[w_adr]);
    end

    assign stall_o = |(rd_ena_i & rd_busy_o);
    assign flag_o  = flag_ena_i & {r_rav, r_cmp};

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: two instances (ZERO_R0 = 0 and 1) share stimulus and are
// compared against a behavioural model of the register file, scoreboard and flags.
module tb_regfile_sb;

    localparam int unsigned DW = 16;
    localparam int unsigned NR = 8;
    localparam int unsigned ND = 3;
    localparam int unsigned AW = 3;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [ND-1:0]     rd_ena;
    logic [ND*AW-1:0]  rd_adr;
    logic              iss_ena;
    logic [AW-1:0]     iss_adr;
    logic              wr_ena;
    logic [AW-1:0]     wr_adr;
    logic [DW-1:0]     wr_data;
    logic              flag_wr;
    logic [2:0]        flag_cmp;
    logic              flag_ra_wr;
    logic              flag_ra;
    logic [3:0]        flag_ena;

    logic [ND*DW-1:0]  d0_data, d1_data;
    logic [ND-1:0]     d0_busy, d1_busy;
    logic              d0_stall, d1_stall;
    logic [3:0]        d0_flag, d1_flag;

    regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(ND), .ZERO_R0(0)) u_dut0 (
        .clk_i(clk), .rst(rst), .rd_ena_i(rd_ena), .rd_adr_i(rd_adr), .rd_data_o(d0_data),
        .rd_busy_o(d0_busy), .stall_o(d0_stall), .iss_ena_i(iss_ena), .iss_adr_i(iss_adr),
        .wr_ena_i(wr_ena), .wr_adr_i(wr_adr), .wr_data_i(wr_data), .flag_wr_i(flag_wr),
        .flag_cmp_i(flag_cmp), .flag_ra_wr_i(flag_ra_wr), .flag_ra_i(flag_ra),
        .flag_ena_i(flag_ena), .flag_o(d0_flag)
    );

    regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(ND), .ZERO_R0(1)) u_dut1 (
        .clk_i(clk), .rst(rst), .rd_ena_i(rd_ena), .rd_adr_i(rd_adr), .rd_data_o(d1_data),
        .rd_busy_o(d1_busy), .stall_o(d1_stall), .iss_ena_i(iss_ena), .iss_adr_i(iss_adr),
        .wr_ena_i(wr_ena), .wr_adr_i(wr_adr), .wr_data_i(wr_data), .flag_wr_i(flag_wr),
        .flag_cmp_i(flag_cmp), .flag_ra_wr_i(flag_ra_wr), .flag_ra_i(flag_ra),
        .flag_ena_i(flag_ena), .flag_o(d1_flag)
    );

    typedef struct {
        logic [ND*DW-1:0] data0;
        logic [ND*DW-1:0] data1;
        logic [ND-1:0]    busy0;
        logic [ND-1:0]    busy1;
        logic             stall0;
        logic             stall1;
        logic [3:0]       flag;
    } exp_t;

    exp_t q_exp[$];

    // Reference state: register contents and pending bits per instance, plus flags.
    logic [DW-1:0] m_reg  [2][NR];
    logic          m_busy [2][NR];
    logic [2:0]    m_cmp;
    logic          m_rav;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit writable(input int z, input logic [AW-1:0] a);
        return !(z == 1 && a == '0);
    endfunction

    task automatic idle();
        rst = 0; rd_ena = '0; rd_adr = '0; iss_ena = 0; iss_adr = '0;
        wr_ena = 0; wr_adr = '0; wr_data = '0; flag_wr = 0; flag_cmp = '0;
        flag_ra_wr = 0; flag_ra = 0; flag_ena = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_rd(input int k, input logic en, input logic [AW-1:0] a);
        rd_ena[k] = en;
        rd_adr[k*AW +: AW] = a;
    endtask

    // Compute this cycle's expected outputs from the model, queue them, then advance the model.
    task automatic apply();
        exp_t             e;
        logic [ND*DW-1:0] dv;
        logic [ND-1:0]    bv;
        logic [AW-1:0]    a;
        for (int z = 0; z < 2; z++) begin
            dv = '0;
            bv = '0;
            for (int k = 0; k < ND; k++) begin
                a = rd_adr[k*AW +: AW];
                if (rd_ena[k] && writable(z, a)) begin
                    if (BYP && wr_ena && wr_adr == a) begin
                        dv[k*DW +: DW] = wr_data;
                        bv[k] = iss_ena && (iss_adr == a);
                    end else begin
                        dv[k*DW +: DW] = m_reg[z][a];
                        bv[k] = m_busy[z][a];
                    end
                end
            end
            if (z == 0) begin
                e.data0 = dv; e.busy0 = bv; e.stall0 = |bv;
            end else begin
                e.data1 = dv; e.busy1 = bv; e.stall1 = |bv;
            end
        end
        e.flag = flag_ena & {m_rav, m_cmp};
        q_exp.push_back(e);

        if (rst) begin
            for (int z = 0; z < 2; z++)
                for (int r = 0; r < NR; r++) begin
                    m_reg[z][r] = '0;
                    m_busy[z][r] = 1'b0;
                end
            m_cmp = '0;
            m_rav = 1'b0;
        end else begin
            for (int z = 0; z < 2; z++) begin
                if (wr_ena && writable(z, wr_adr)) begin
                    m_reg[z][wr_adr] = wr_data;
                    m_busy[z][wr_adr] = 1'b0;
                end
                if (iss_ena && writable(z, iss_adr)) m_busy[z][iss_adr] = 1'b1;
            end
            if (flag_wr) m_cmp = flag_cmp;
            if (flag_ra_wr) m_rav = flag_ra;
        end
    endtask

    // Monitor: compares whatever the DUTs present mid-cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_exp.size() != 0) begin
                e = q_exp.pop_front();
                chk("data0", 64'(d0_data), 64'(e.data0));
                chk("data1", 64'(d1_data), 64'(e.data1));
                chk("busy0", 64'(d0_busy), 64'(e.busy0));
                chk("busy1", 64'(d1_busy), 64'(e.busy1));
                chk("stall0", 64'(d0_stall), 64'(e.stall0));
                chk("stall1", 64'(d1_stall), 64'(e.stall1));
                chk("flag0", 64'(d0_flag), 64'(e.flag));
                chk("flag1", 64'(d1_flag), 64'(e.flag));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        for (int z = 0; z < 2; z++)
            for (int r = 0; r < NR; r++) begin
                m_reg[z][r] = '0;
                m_busy[z][r] = 1'b0;
            end
        m_cmp = '0;
        m_rav = 1'b0;

        // Reset clears earlier writes.
        cyc(); wr_ena = 1; wr_adr = 3; wr_data = 16'h1234; apply();
        cyc(); set_rd(0, 1, 3); flag_ena = 4'hF; rst = 1; apply();
        cyc(); for (int k = 0; k < ND; k++) set_rd(k, 1, 3); flag_ena = 4'hF; apply();

        // Write then read with mixed enables.
        cyc(); wr_ena = 1; wr_adr = 5; wr_data = 16'hBEEF; apply();
        cyc(); set_rd(0, 1, 5); set_rd(1, 0, 5); set_rd(2, 1, 5); apply();

        // Scoreboard set and clear.
        cyc(); iss_ena = 1; iss_adr = 2; apply();
        cyc(); set_rd(0, 1, 2); wr_ena = 1; wr_adr = 2; wr_data = 16'h0042; apply();
        cyc(); set_rd(0, 1, 2); apply();

        // Same-cycle issue and write, then same-cycle read of a write target.
        cyc(); iss_ena = 1; iss_adr = 4; wr_ena = 1; wr_adr = 4; wr_data = 16'h0007; apply();
        cyc(); set_rd(1, 1, 4); apply();
        cyc(); set_rd(2, 1, 6); wr_ena = 1; wr_adr = 6; wr_data = 16'h55AA; apply();
        cyc(); set_rd(2, 1, 6); apply();

        // Flags with partial and full output enables.
        cyc(); flag_wr = 1; flag_cmp = 3'b100; flag_ra_wr = 1; flag_ra = 1; apply();
        cyc(); flag_ena = 4'b1011; apply();
        cyc(); flag_ena = 4'hF; apply();

        // Writes and issues to r0.
        cyc(); wr_ena = 1; wr_adr = 0; wr_data = 16'hFFFF; iss_ena = 1; iss_adr = 0; apply();
        cyc(); for (int k = 0; k < ND; k++) set_rd(k, 1, 0); apply();

        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst        = ($urandom_range(0, 63) == 0);
            rd_ena     = ND'($urandom);
            rd_adr     = (ND*AW)'($urandom);
            iss_ena    = ($urandom_range(0, 2) == 0);
            iss_adr    = AW'($urandom);
            wr_ena     = ($urandom_range(0, 1) == 0);
            wr_adr     = AW'($urandom);
            wr_data    = DW'($urandom);
            flag_wr    = ($urandom_range(0, 3) == 0);
            flag_cmp   = 3'($urandom);
            flag_ra_wr = ($urandom_range(0, 3) == 0);
            flag_ra    = 1'($urandom);
            flag_ena   = 4'($urandom);
            apply();
        end

        cyc();
        cyc();
        chk("drain", 64'(q_exp.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
